glyph_pixel_streamer: RTL and testbench



---
 rtl/glyph_pkg.sv | 20 ++
 rtl/glyph_pixel_streamer_if.sv | 13 +
 rtl/glyph_pixel_streamer.sv | 100 ++++++++++
 tb/tb_glyph_pixel_streamer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared constants, FSM states and bitmap indexing for the 5x7 glyph text path.
package glyph_pkg;

  localparam int GLYPH_W    = 5;
  localparam int GLYPH_H    = 7;
  localparam int GLYPH_BITS = 35;
  localparam int PIX_W      = 24;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  // Row 0 is the top, col 0 the left; the top-left pixel lives in the MSB.
  function automatic logic [5:0] bit_index(input logic [2:0] row, input logic [2:0] col);
    return 6'(GLYPH_BITS - 1) - (6'(row) * 6'(GLYPH_W) + 6'(col));
  endfunction

endpackage

// File: rtl/glyph_pixel_streamer_if.sv
// Pixel-word stream from the glyph streamer to the WS2812B bit encoder.
interface glyph_pixel_streamer_if;
  import glyph_pkg::*;

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;

  modport master (output pix_valid, pix_data, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_last, output pix_ready);

endinterface

// File: rtl/glyph_pixel_streamer.sv
// Fetches a 5x7 glyph from the character ROM and streams it as serpentine
// column-major GRB pixel words, followed by GAP_COLS dark columns.
module glyph_pixel_streamer
  import glyph_pkg::*;
#(
  parameter int GAP_COLS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic [6:0]            char_code,
  input  logic [PIX_W-1:0]      color,
  output logic [6:0]            rom_addr,
  input  logic [GLYPH_BITS-1:0] rom_data,
  glyph_pixel_streamer_if.master pix,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] LAST_COL = 3'(GLYPH_W - 1 + GAP_COLS);
  localparam logic [2:0] ROW_MAX  = 3'(GLYPH_H - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  fire;
  logic                  col_end;
  logic                  last_pix;
  logic                  lit;
  logic [2:0]            col;
  logic [2:0]            row;
  logic [PIX_W-1:0]      col_reg;
  logic [GLYPH_BITS-1:0] glyph_reg;

  always_comb begin
    state_nxt     = state;
    char_ready    = 1'b0;
    pix.pix_valid = 1'b0;
    accept        = 1'b0;
    fire          = 1'b0;
    // Even columns run top-down, odd columns bottom-up.
    col_end  = col[0] ? (row == 3'd0) : (row == ROW_MAX);
    last_pix = col_end && (col == LAST_COL);
    case (state)
      IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = EMIT;
      EMIT: begin
        pix.pix_valid = 1'b1;
        fire          = pix.pix_ready;
        if (fire && last_pix) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lit = 1'b0;
    if (col < 3'(GLYPH_W)) lit = glyph_reg[bit_index(row, col)];
  end

  assign pix.pix_data = ((state == EMIT) && lit) ? col_reg : '0;
  assign pix.pix_last = (state == EMIT) && last_pix;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      done     <= 1'b0;
      col      <= '0;
      row      <= '0;
    end else begin
      state <= state_nxt;
      done  <= fire && last_pix;
      if (accept) rom_addr <= char_code;
      if (state == LOAD) begin
        col <= '0;
        row <= '0;
      end else if (fire && !last_pix) begin
        // At a column boundary the row already sits where the next column starts.
        if (col_end)     col <= col + 3'd1;
        else if (col[0]) row <= row - 3'd1;
        else             row <= row + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)        col_reg   <= color;
    if (state == LOAD) glyph_reg <= rom_data;
  end

endmodule

// File: tb/tb_glyph_pixel_streamer.sv
// Scoreboard bench: a reference model queues expected pixel words on each
// accepted character; an independent monitor checks every transferred word.
module tb_glyph_pixel_streamer;

  localparam int GAP = 1;
  localparam int N   = 7 * (5 + GAP);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [6:0]  char_code = '0;
  logic [23:0] color = '0;
  logic [6:0]  rom_addr;
  logic [34:0] rom_data;
  logic        busy;
  logic        done;

  logic        rom_force = 1'b0;
  logic [34:0] rom_force_val = '0;
  int          ready_mode = 0;

  int checks = 0;
  int passed = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  logic [24:0] exp_q[$];

  glyph_pixel_streamer_if pif();

  glyph_pixel_streamer #(.GAP_COLS(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_code (char_code),
    .color     (color),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix       (pif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] rom_fn(input logic [6:0] code);
    if (code < 7'd32) return '1;
    return {5{code}} ^ (35'(code) * 35'h0_1357_9BDF);
  endfunction

  assign rom_data = rom_force ? rom_force_val : rom_fn(rom_addr);

  // Reference: glyph + gap columns, serpentine column-major.
  function automatic void push_glyph(input logic [34:0] bm, input logic [23:0] clr);
    for (int c = 0; c < 5 + GAP; c++) begin
      for (int k = 0; k < 7; k++) begin
        int r;
        bit lit;
        r   = (c % 2 == 0) ? k : 6 - k;
        lit = (c < 5) ? bm[34 - (r * 5 + c)] : 1'b0;
        exp_q.push_back({(c == 4 + GAP) && (k == 6), lit ? clr : 24'h0});
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       pif.pix_ready = 1'b1;
      1:       pif.pix_ready = 1'($urandom_range(0, 1));
      default: pif.pix_ready = 1'b0;
    endcase
  end

  // Monitor: samples on the falling edge, i.e. what transfers at the next rising edge.
  logic        stall_valid = 1'b0;
  logic        prev_rst = 1'b1;
  logic [23:0] held_data = '0;
  logic        held_last = 1'b0;
  logic        done_pending = 1'b0;
  always @(negedge clk) begin
    logic [24:0] e;
    logic        dn;
    dn = 1'b0;
    chk("done_pulse", 64'(done), 64'(done_pending));
    if (done) done_cnt++;
    if (stall_valid && !prev_rst) begin
      chk("stall_valid", 64'(pif.pix_valid), 64'd1);
      chk("stall_data", 64'(pif.pix_data), 64'(held_data));
      chk("stall_last", 64'(pif.pix_last), 64'(held_last));
    end
    if (pif.pix_valid && pif.pix_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pix_unexpected got=%0h expected=none", pif.pix_data);
      end else begin
        e = exp_q.pop_front();
        chk("pix_data", 64'(pif.pix_data), 64'(e[23:0]));
        chk("pix_last", 64'(pif.pix_last), 64'(e[24]));
        dn = e[24];
      end
    end
    stall_valid  = pif.pix_valid && !pif.pix_ready;
    held_data    = pif.pix_data;
    held_last    = pif.pix_last;
    prev_rst     = rst;
    done_pending = dn;
  end

  task automatic run_char(input logic [6:0] code, input logic [23:0] clr,
                          input bit wait_end, input bit timing);
    logic [34:0] bm;
    int cyc;
    bm = rom_force ? rom_force_val : rom_fn(code);
    @(posedge clk); #1;
    char_code  = code;
    color      = clr;
    char_valid = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!char_ready && cyc < 200);
    if (!char_ready) begin
      checks++;
      $display("FAIL accept_timeout got=char_ready 0 expected=1");
      char_valid = 1'b0;
      return;
    end
    push_glyph(bm, clr);
    @(posedge clk); #1;
    char_valid = 1'b0;
    color      = 24'($urandom);
    char_code  = 7'($urandom);
    @(negedge clk);
    chk("lat_load_valid", 64'(pif.pix_valid), 64'd0);
    chk("rom_addr", 64'(rom_addr), 64'(code));
    chk("busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat_emit_valid", 64'(pif.pix_valid), 64'd1);
    if (wait_end) begin
      cyc = 2;
      while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
      chk("done_seen", 64'(done), 64'd1);
      if (timing) chk("glyph_cycles", 64'(cyc), 64'(N + 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    int base;
    int cyc;
    int accepts;
    pif.pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_char_ready", 64'(char_ready), 64'd1);
    chk("rst_pix_valid", 64'(pif.pix_valid), 64'd0);
    chk("rst_pix_last", 64'(pif.pix_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_pix_data", 64'(pif.pix_data), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    rom_force = 1'b1;
    rom_force_val = 35'h1;
    run_char(7'h41, 24'h00FF00, 1, 1);
    rom_force_val = 35'h4_0000_0000;
    run_char(7'h42, 24'($urandom), 1, 1);
    rom_force_val = 35'h1_0000_0000;
    run_char(7'h43, 24'($urandom), 1, 1);
    rom_force = 1'b0;
    run_char(7'h05, 24'h123456, 1, 1);

    ready_mode = 1;
    for (int i = 0; i < 4; i++) begin
      r64 = {$urandom, $urandom};
      rom_force = 1'b1;
      rom_force_val = r64[34:0];
      run_char(7'($urandom_range(32, 127)), 24'($urandom), 1, 0);
    end
    ready_mode = 0;

    // Reset in the middle of a glyph after ten pixels have transferred.
    r64 = {$urandom, $urandom};
    rom_force_val = r64[34:0];
    base = acc_cnt;
    run_char(7'h50, 24'($urandom), 0, 0);
    cyc = 0;
    do begin @(posedge clk); cyc++; end while (acc_cnt - base < 10 && cyc < 200);
    chk("rst_mid_reached", 64'(acc_cnt - base), 64'd10);
    #2;
    rst = 1'b1;
    pif.pix_ready = 1'b0;
    ready_mode = 2;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_pix_valid", 64'(pif.pix_valid), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    chk("rstmid_char_ready", 64'(char_ready), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd0);
    exp_q.delete();
    ready_mode = 0;
    r64 = {$urandom, $urandom};
    rom_force_val = r64[34:0];
    run_char(7'h51, 24'($urandom), 1, 1);

    // Reset coinciding with a request: nothing may be accepted.
    @(posedge clk); #1;
    rst = 1'b1;
    char_valid = 1'b1;
    char_code = 7'h41;
    @(posedge clk); #1;
    rst = 1'b0;
    char_valid = 1'b0;
    @(negedge clk);
    chk("rstreq_busy", 64'(busy), 64'd0);
    chk("rstreq_rom_addr", 64'(rom_addr), 64'd0);
    @(negedge clk);
    chk("rstreq_busy2", 64'(busy), 64'd0);

    // Request held continuously while colour and code keep changing.
    rom_force = 1'b0;
    base = done_cnt;
    accepts = 0;
    @(posedge clk); #1;
    char_code = 7'h61;
    color = 24'($urandom);
    char_valid = 1'b1;
    cyc = 0;
    while (accepts < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (char_ready) begin
        if (accepts == 1) chk("accept_in_done", 64'(done), 64'd1);
        push_glyph(rom_fn(char_code), color);
        accepts++;
      end
      @(posedge clk); #1;
      if (accepts == 2) char_valid = 1'b0;
      else begin
        color = 24'($urandom);
        if (accepts == 1) char_code = 7'h7A;
      end
    end
    chk("hold_accepts", 64'(accepts), 64'd2);
    cyc = 0;
    while (!done && cyc < 500) begin @(negedge clk); cyc++; end
    chk("hold_done_seen", 64'(done), 64'd1);
    @(negedge clk);
    chk("hold_done_pulses", 64'(done_cnt - base), 64'd2);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
